// File: rtl/mem_loader_if.sv
// mem_loader_if: byte-stream, CPU-side RAM port and RAM-side port of the
// boot loader, bundled into one interface.
//   i_valid/i_data/o_ready    : byte stream into the loader
//   cpu_wrEn/cpu_addr/cpu_data: CPU write port (used after loading is done)
//   ram_we/ram_addr/ram_data  : block RAM write port
// Modports:
//   slave  : the loader's view
//   master : the environment's view (stream source, CPU, RAM)
interface mem_loader_if #(
  parameter int unsigned SIZE = 14
);
  logic            i_valid;
  logic [7:0]      i_data;
  logic            o_ready;
  logic            cpu_wrEn;
  logic [SIZE-1:0] cpu_addr;
  logic [31:0]     cpu_data;
  logic            ram_we;
  logic [SIZE-1:0] ram_addr;
  logic [31:0]     ram_data;

  modport slave (
    input  i_valid, i_data, cpu_wrEn, cpu_addr, cpu_data,
    output o_ready, ram_we, ram_addr, ram_data
  );

  modport master (
    output i_valid, i_data, cpu_wrEn, cpu_addr, cpu_data,
    input  o_ready, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: boot-time program loader. Assembles {addr[15:0], data[31:0]}
// big-endian records from a byte stream into single-cycle RAM writes while
// holding the CPU in reset. Address 16'hFFFF terminates loading; the CPU is
// then released and its write port passes straight through to the RAM.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : stream / CPU / RAM signals (mem_loader_if.slave)
//   o_cpu_hold : active-high CPU reset, low once the terminator is accepted
//   o_done     : terminator received (sticky)
//   o_err      : out-of-range address seen (sticky)
//   o_word_cnt : words written by the loader, saturating
module mem_loader #(
  parameter int unsigned SIZE  = 14,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst,
  mem_loader_if.slave   bus,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_err,
  output logic [15:0]   o_word_cnt
);

  typedef enum logic [2:0] {A_HI, A_LO, D3, D2, D1, D0, WR, DONE} state_t;

  state_t          state, state_nxt;
  logic            rdy;
  logic            accept;
  logic [15:0]     addr_q;
  logic [23:0]     data_q;
  logic [15:0]     addr_full;
  logic            is_term;
  logic            out_of_range;
  logic            oor_q;
  logic            ld_we;
  logic [SIZE-1:0] ld_addr;
  logic [31:0]     ld_data;

  // Address as it stands once the low byte on the bus is taken.
  assign addr_full    = {addr_q[15:8], bus.i_data};
  assign is_term      = (addr_full == 16'hFFFF);
  assign out_of_range = ({16'd0, addr_full} >= DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= A_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = (state != WR) && (state != DONE);
    accept    = bus.i_valid && rdy;
    case (state)
      A_HI:    if (accept) state_nxt = A_LO;
      A_LO:    if (accept) state_nxt = is_term ? DONE : D3;
      D3:      if (accept) state_nxt = D2;
      D2:      if (accept) state_nxt = D1;
      D1:      if (accept) state_nxt = D0;
      D0:      if (accept) state_nxt = WR;
      WR:      state_nxt = A_HI;
      DONE:    state_nxt = DONE;
      default: state_nxt = A_HI;
    endcase
  end

  assign bus.o_ready = rdy && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      oor_q      <= 1'b0;
      ld_we      <= 1'b0;
      ld_addr    <= '0;
      ld_data    <= '0;
      o_cpu_hold <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_word_cnt <= '0;
    end else begin
      ld_we <= 1'b0;
      if (accept) begin
        case (state)
          A_HI: addr_q[15:8] <= bus.i_data;
          A_LO: begin
            addr_q[7:0] <= bus.i_data;
            if (is_term) begin
              o_done     <= 1'b1;
              o_cpu_hold <= 1'b0;
            end else begin
              oor_q <= out_of_range;
              if (out_of_range) o_err <= 1'b1;
            end
          end
          D3, D2, D1: data_q <= {data_q[15:0], bus.i_data};
          // Write strobe registered here so it is high exactly in WR.
          D0: if (!oor_q) begin
            ld_we   <= 1'b1;
            ld_addr <= addr_q[SIZE-1:0];
            ld_data <= {data_q, bus.i_data};
          end
          default: ;
        endcase
      end
      if (state == WR && !oor_q && o_word_cnt != '1) begin
        o_word_cnt <= o_word_cnt + 16'd1;
      end
    end
  end

  // CPU owns the RAM port only once loading has finished.
  always_comb begin
    bus.ram_we   = ld_we;
    bus.ram_addr = ld_addr;
    bus.ram_data = ld_data;
    if (state == DONE) begin
      bus.ram_we   = bus.cpu_wrEn;
      bus.ram_addr = bus.cpu_addr;
      bus.ram_data = bus.cpu_data;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized, self-checking bench for mem_loader. A record-level
// reference model predicts every output each cycle; directed sequences add
// literal expectations.
module tb_mem_loader;

  localparam int unsigned SIZE  = 14;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_cpu_hold, o_done, o_err;
  logic [15:0] o_word_cnt;

  mem_loader_if #(.SIZE(SIZE)) bus ();

  mem_loader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .o_cpu_hold (o_cpu_hold),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_word_cnt (o_word_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural block RAM on the loader's output port.
  logic [31:0] tb_ram [0:(1<<SIZE)-1];
  always @(posedge clk) if (bus.ram_we) tb_ram[bus.ram_addr] <= bus.ram_data;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (record level) ----------------
  logic [7:0]  m_rec[$];
  logic [31:0] mem[int];
  bit          m_done, m_err, m_wr, m_oor, m_acc;
  int          m_cnt;
  logic [13:0] m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_rec.delete();
    m_done = 0; m_err = 0; m_wr = 0; m_oor = 0; m_acc = 0;
    m_cnt = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    logic [15:0] a;
    logic [31:0] w;
    bit acc;
    m_acc = 0;
    if (!rst) return;
    acc = bus.i_valid && !m_done && !m_wr;
    if (m_wr) begin
      if (!m_oor && m_cnt != 16'hFFFF) m_cnt++;
      m_wr = 0;
    end
    if (acc) begin
      m_acc = 1;
      m_rec.push_back(bus.i_data);
      if (m_rec.size() == 2) begin
        a = {m_rec[0], m_rec[1]};
        if (a == 16'hFFFF) begin
          m_done = 1;
          m_rec.delete();
        end else begin
          m_oor = (int'(a) >= int'(DEPTH));
          if (m_oor) m_err = 1;
        end
      end else if (m_rec.size() == 6) begin
        a = {m_rec[0], m_rec[1]};
        w = {m_rec[2], m_rec[3], m_rec[4], m_rec[5]};
        m_wr = 1;
        if (!m_oor) begin
          m_addr = a[13:0];
          m_data = w;
          mem[int'(a)] = w;
        end
        m_rec.delete();
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_ready", {31'd0, bus.o_ready}, {31'd0, rst && !m_done && !m_wr});
      check("o_cpu_hold", {31'd0, o_cpu_hold}, {31'd0, !m_done});
      check("o_done", {31'd0, o_done}, {31'd0, m_done});
      check("o_err", {31'd0, o_err}, {31'd0, m_err});
      check("o_word_cnt", {16'd0, o_word_cnt}, 32'(m_cnt));
      if (m_done) begin
        check("ram_we_pt", {31'd0, bus.ram_we}, {31'd0, bus.cpu_wrEn});
        check("ram_addr_pt", {18'd0, bus.ram_addr}, {18'd0, bus.cpu_addr});
        check("ram_data_pt", bus.ram_data, bus.cpu_data);
      end else begin
        check("ram_we", {31'd0, bus.ram_we}, {31'd0, m_wr && !m_oor});
        check("ram_addr", {18'd0, bus.ram_addr}, {18'd0, m_addr});
        check("ram_data", bus.ram_data, m_data);
      end
    end
  end

  // Loader-write monitor for the literal checks.
  int          wr_events = 0;
  logic [13:0] last_wa;
  logic [31:0] last_wd;
  always @(negedge clk) begin
    if (rst && !o_done && bus.ram_we) begin
      wr_events++;
      last_wa = bus.ram_addr;
      last_wd = bus.ram_data;
    end
  end

  // ---------------- stimulus ----------------
  bit cpu_rand = 1;

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (cpu_rand) begin
      bus.cpu_wrEn = 1'($urandom_range(0, 1));
      bus.cpu_addr = 14'($urandom);
      bus.cpu_data = $urandom;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      bus.i_valid = 1'b0;
      bus.i_data  = 8'($urandom);
      step();
    end
    bus.i_valid = 1'b1;
    bus.i_data  = b;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc && n < 16);
    if (!m_acc) check("accept_timeout", 32'd0, 32'd1);
    bus.i_valid = 1'b0;
  endtask

  task automatic send_record(input logic [15:0] a, input logic [31:0] d, input int gap, input bit rnd_gap);
    logic [7:0] bytes [6];
    bytes[0] = a[15:8];  bytes[1] = a[7:0];
    bytes[2] = d[31:24]; bytes[3] = d[23:16];
    bytes[4] = d[15:8];  bytes[5] = d[7:0];
    for (int i = 0; i < 6; i++) begin
      send_byte(bytes[i], rnd_gap ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3))) : gap);
    end
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_hold", {31'd0, o_cpu_hold}, 32'd1);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_cnt", {16'd0, o_word_cnt}, 32'd0);
    check("rst_we", {31'd0, bus.ram_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    bus.cpu_wrEn = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    model_reset();
    #2;
    chk_en = 1;
    do_reset();

    // Single word, back-to-back.
    send_record(16'h0005, 32'hDEADBEEF, 0, 0);
    check("wr_we", {31'd0, bus.ram_we}, 32'd1);
    check("wr_addr", {18'd0, bus.ram_addr}, 32'd5);
    check("wr_data", bus.ram_data, 32'hDEADBEEF);
    check("wr_ready", {31'd0, bus.o_ready}, 32'd0);
    step(); step();
    check("single_cnt", {16'd0, o_word_cnt}, 32'd1);
    check("single_events", wr_events, 32'd1);

    // Same record with 3-cycle gaps.
    send_record(16'h0005, 32'hDEADBEEF, 3, 0);
    step(); step();
    check("gap_events", wr_events, 32'd2);
    check("gap_addr", {18'd0, last_wa}, 32'd5);
    check("gap_data", last_wd, 32'hDEADBEEF);
    check("gap_cnt", {16'd0, o_word_cnt}, 32'd2);

    // Out-of-range address, then a good record.
    send_record(16'h0400, 32'h11223344, 0, 0);
    step(); step();
    check("oor_err", {31'd0, o_err}, 32'd1);
    check("oor_events", wr_events, 32'd2);
    check("oor_cnt", {16'd0, o_word_cnt}, 32'd2);
    send_record(16'h0007, 32'h0000002A, 0, 0);
    step(); step();
    check("after_oor_ram7", tb_ram[7], 32'd42);
    check("after_oor_cnt", {16'd0, o_word_cnt}, 32'd3);

    // Reset in the middle of a record.
    send_byte(8'h00, 0); send_byte(8'h09, 0); send_byte(8'hAB, 0);
    do_reset();
    send_record(16'h0009, 32'h00000001, 0, 0);
    step(); step();
    check("midrst_events", wr_events, 32'd4);
    check("midrst_addr", {18'd0, last_wa}, 32'd9);
    check("midrst_data", last_wd, 32'd1);
    check("midrst_cnt", {16'd0, o_word_cnt}, 32'd1);

    // Random records, some out of range, random gaps.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 16'hFFFE));
      else                           a = 16'($urandom_range(0, DEPTH - 1));
      send_record(a, $urandom, 0, 1);
    end
    step(); step();
    foreach (mem[k]) check("mem_content", tb_ram[k[13:0]], mem[k]);

    // Two records then the terminator.
    do_reset();
    send_record(16'h0000, 32'hA5A5_0000, 0, 0);
    send_record(16'h0001, 32'h0000_5A5A, 0, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    check("term_done", {31'd0, o_done}, 32'd1);
    check("term_hold", {31'd0, o_cpu_hold}, 32'd0);
    check("term_cnt", {16'd0, o_word_cnt}, 32'd2);
    check("term_ready", {31'd0, bus.o_ready}, 32'd0);
    bus.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_data = 8'($urandom);
      step();
    end
    bus.i_valid = 1'b0;
    check("ignored_cnt", {16'd0, o_word_cnt}, 32'd2);

    // Pass-through write from the CPU.
    cpu_rand = 0;
    bus.cpu_wrEn = 1'b1;
    bus.cpu_addr = 14'd50;
    bus.cpu_data = 32'h1234;
    #1;
    check("pt_we", {31'd0, bus.ram_we}, 32'd1);
    check("pt_addr", {18'd0, bus.ram_addr}, 32'd50);
    check("pt_data", bus.ram_data, 32'h1234);
    step();
    bus.cpu_wrEn = 1'b0;
    check("pt_ram50", tb_ram[50], 32'h1234);
    cpu_rand = 1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
